// File: rtl/vector_reg_file.sv
// vector_reg_file: NREGS vector registers of N lanes x BITS bits.
// Two registered full-width read ports, one masked full-width write port,
// and an element sequencer that streams one register in (load) or out
// (store) one element per valid/ready handshake.
module vector_reg_file #(
  parameter int BITS  = 8,
  parameter int N     = 64,
  parameter int NREGS = 8,
  localparam int AW   = (NREGS > 1) ? $clog2(NREGS) : 1,
  localparam int IW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic [N-1:0][BITS-1:0]   wr_data,
  input  logic [N-1:0]             wr_mask,
  input  logic [AW-1:0]            rd_a_addr,
  input  logic [AW-1:0]            rd_b_addr,
  output logic [N-1:0][BITS-1:0]   rd_a_data,
  output logic [N-1:0][BITS-1:0]   rd_b_data,
  input  logic                     ld_start,
  input  logic [AW-1:0]            ld_addr,
  input  logic [BITS-1:0]          ld_data,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic                     st_start,
  input  logic [AW-1:0]            st_addr,
  output logic [BITS-1:0]          st_data,
  output logic                     st_valid,
  input  logic                     st_ready,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_STORE = 2'd2
  } state_e;

  localparam int              NM1      = N - 1;
  localparam logic [IW-1:0]   IDX_LAST = NM1[IW-1:0];
  localparam logic [IW-1:0]   IDX_ONE  = IW'(1);
  localparam logic [IW-1:0]   IDX_ZERO = IW'(0);
  localparam logic [AW:0]     NREGS_C  = NREGS[AW:0];

  // Addresses at or above NREGS (only possible for non power-of-2 NREGS)
  // are illegal: writes to them are dropped and reads return zero.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return ({1'b0, a} < NREGS_C);
  endfunction

  state_e                   state_q;
  logic [IW-1:0]            idx_q;
  logic [AW-1:0]            reg_q;
  logic                     ld_ready_q;
  logic                     st_valid_q;
  logic [BITS-1:0]          st_data_q;
  logic                     busy_q;
  logic                     done_q;

  logic [N-1:0][BITS-1:0]   mem_q [NREGS];
  logic [N-1:0][BITS-1:0]   mem_d [NREGS];
  logic [N-1:0][BITS-1:0]   rd_a_q;
  logic [N-1:0][BITS-1:0]   rd_b_q;
  logic [N-1:0][BITS-1:0]   rd_a_d;
  logic [N-1:0][BITS-1:0]   rd_b_d;

  logic                     ld_we_s;
  logic                     wr_ok_s;
  logic [AW-1:0]            st_reg_s;
  logic [IW-1:0]            st_idx_s;
  logic [BITS-1:0]          st_elem_s;

  assign ld_we_s = (state_q == S_LOAD) && ld_valid && addr_ok(reg_q);
  assign wr_ok_s = wr_en && addr_ok(wr_addr);

  // Next storage image: the parallel write wins over a load element on the same lane.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      for (int i = 0; i < N; i++) begin
        mem_d[r][i] = (wr_ok_s && (wr_addr == r[AW-1:0]) && wr_mask[i]) ? wr_data[i] :
                      ((ld_we_s && (reg_q == r[AW-1:0]) && (idx_q == i[IW-1:0])) ? ld_data :
                       mem_q[r][i]);
      end
    end
  end

  // Read data is taken from the next storage image so same-cycle writes bypass.
  always_comb begin
    rd_a_d = addr_ok(rd_a_addr) ? mem_d[rd_a_addr] : '0;
    rd_b_d = addr_ok(rd_b_addr) ? mem_d[rd_b_addr] : '0;
  end

  // Element the store port will present after this edge (live, not snapshotted).
  always_comb begin
    st_reg_s = reg_q;
    st_idx_s = idx_q;
    case (state_q)
      S_IDLE: begin
        st_reg_s = st_addr;
        st_idx_s = IDX_ZERO;
      end
      S_STORE: begin
        if (st_ready && (idx_q != IDX_LAST)) begin
          st_idx_s = idx_q + IDX_ONE;
        end else begin
          st_idx_s = idx_q;
        end
      end
      default: begin
        st_reg_s = reg_q;
        st_idx_s = idx_q;
      end
    endcase
    st_elem_s = addr_ok(st_reg_s) ? mem_d[st_reg_s][st_idx_s] : {BITS{1'b0}};
  end

  // Storage array update; reset clears every register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  // Registered read ports.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_a_q <= '0;
      rd_b_q <= '0;
    end else begin
      rd_a_q <= rd_a_d;
      rd_b_q <= rd_b_d;
    end
  end

  // Load/store sequencer with registered handshake and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= IDX_ZERO;
      reg_q      <= '0;
      ld_ready_q <= 1'b0;
      st_valid_q <= 1'b0;
      st_data_q  <= {BITS{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          idx_q <= IDX_ZERO;
          if (ld_start) begin
            state_q    <= S_LOAD;
            reg_q      <= ld_addr;
            ld_ready_q <= 1'b1;
            st_valid_q <= 1'b0;
            st_data_q  <= {BITS{1'b0}};
            busy_q     <= 1'b1;
          end else if (st_start) begin
            state_q    <= S_STORE;
            reg_q      <= st_addr;
            ld_ready_q <= 1'b0;
            st_valid_q <= 1'b1;
            st_data_q  <= st_elem_s;
            busy_q     <= 1'b1;
          end else begin
            ld_ready_q <= 1'b0;
            st_valid_q <= 1'b0;
            st_data_q  <= {BITS{1'b0}};
            busy_q     <= 1'b0;
          end
        end
        S_LOAD: begin
          if (ld_valid && (idx_q == IDX_LAST)) begin
            state_q    <= S_IDLE;
            idx_q      <= IDX_ZERO;
            ld_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
          end else if (ld_valid) begin
            idx_q <= idx_q + IDX_ONE;
          end else begin
            idx_q <= idx_q;
          end
        end
        S_STORE: begin
          if (st_ready && (idx_q == IDX_LAST)) begin
            state_q    <= S_IDLE;
            idx_q      <= IDX_ZERO;
            st_valid_q <= 1'b0;
            st_data_q  <= {BITS{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
          end else begin
            idx_q     <= st_idx_s;
            st_data_q <= st_elem_s;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          idx_q      <= IDX_ZERO;
          ld_ready_q <= 1'b0;
          st_valid_q <= 1'b0;
          st_data_q  <= {BITS{1'b0}};
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign rd_a_data = rd_a_q;
  assign rd_b_data = rd_b_q;
  assign ld_ready  = ld_ready_q;
  assign st_valid  = st_valid_q;
  assign st_data   = st_data_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_vector_reg_file.sv
// Bench for vector_reg_file: table of parallel write/read vectors, directed
// load/store/collision/reset sequences and a randomized phase, all checked
// against an array-based model of the register file and sequencer.
module tb_vector_reg_file;

  localparam int BITS  = 8;
  localparam int N     = 64;
  localparam int NREGS = 8;
  localparam int AW    = 3;
  localparam int VW    = N * BITS;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   wr_en;
  logic [AW-1:0]          wr_addr;
  logic [N-1:0][BITS-1:0] wr_data;
  logic [N-1:0]           wr_mask;
  logic [AW-1:0]          rd_a_addr, rd_b_addr;
  logic [N-1:0][BITS-1:0] rd_a_data, rd_b_data;
  logic                   ld_start;
  logic [AW-1:0]          ld_addr;
  logic [BITS-1:0]        ld_data;
  logic                   ld_valid, ld_ready;
  logic                   st_start;
  logic [AW-1:0]          st_addr;
  logic [BITS-1:0]        st_data;
  logic                   st_valid, st_ready;
  logic                   busy, done;

  always #5 clk = ~clk;

  vector_reg_file #(.BITS(BITS), .N(N), .NREGS(NREGS)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
    .rd_a_addr(rd_a_addr), .rd_b_addr(rd_b_addr),
    .rd_a_data(rd_a_data), .rd_b_data(rd_b_data),
    .ld_start(ld_start), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready),
    .st_start(st_start), .st_addr(st_addr), .st_data(st_data),
    .st_valid(st_valid), .st_ready(st_ready),
    .busy(busy), .done(done)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: plain storage array plus abstract sequencer position.
  logic [BITS-1:0] m [NREGS][N];
  int m_mode;   // 0 idle, 1 load, 2 store
  int m_reg;
  int m_idx;
  bit m_done;

  typedef struct {
    logic [AW-1:0]  wa;
    logic [N-1:0]   mask;
    logic [BITS-1:0] base;
    logic [AW-1:0]  ra;
    logic [AW-1:0]  rb;
    logic [VW-1:0]  exp_a;
    logic [VW-1:0]  exp_b;
  } vec_t;

  vec_t tbl [6];
  logic [BITS-1:0] tm [NREGS][N];

  function automatic logic [VW-1:0] mrow(input int r);
    logic [VW-1:0] v;
    for (int i = 0; i < N; i++) v[i*BITS +: BITS] = m[r][i];
    return v;
  endfunction

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < NREGS; r++)
      for (int i = 0; i < N; i++) m[r][i] = '0;
    m_mode = 0; m_reg = 0; m_idx = 0; m_done = 1'b0;
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_mask = '0;
    rd_a_addr = '0; rd_b_addr = '0;
    ld_start = 1'b0; ld_addr = '0; ld_data = '0; ld_valid = 1'b0;
    st_start = 1'b0; st_addr = '0; st_ready = 1'b0;
  endtask

  // One clock edge: advance the model with the inputs present at the edge,
  // then compare every output just after the edge.
  task automatic tick();
    bit hl, hs;
    logic [BITS-1:0] exp_st;
    @(posedge clk);
    hl = (m_mode == 1) && ld_valid;
    hs = (m_mode == 2) && st_ready;
    if (hl) m[m_reg][m_idx] = ld_data;
    if (wr_en)
      for (int i = 0; i < N; i++) if (wr_mask[i]) m[wr_addr][i] = wr_data[i];
    m_done = 1'b0;
    if (hl || hs) begin
      if (m_idx == N - 1) begin m_mode = 0; m_idx = 0; m_done = 1'b1; end
      else m_idx++;
    end else if (m_mode == 0) begin
      if (ld_start) begin m_mode = 1; m_reg = ld_addr; m_idx = 0; end
      else if (st_start) begin m_mode = 2; m_reg = st_addr; m_idx = 0; end
    end
    #1;
    exp_st = (m_mode == 2) ? m[m_reg][m_idx] : 8'h00;
    chk("rd_a", rd_a_data, mrow(rd_a_addr));
    chk("rd_b", rd_b_data, mrow(rd_b_addr));
    chk("status", {busy, done, ld_ready, st_valid, st_data},
        {(m_mode != 0), m_done, (m_mode == 1), (m_mode == 2), exp_st});
  endtask

  initial begin
    int hs_cnt, dones, busy_gap, bad;
    bit seen;
    logic [BITS-1:0] q [$];
    logic [VW-1:0] expv;

    idle_inputs();
    model_clear();
    rst = 1'b1;
    #3;
    chk("reset_rd", {rd_a_data, rd_b_data}, '0);
    chk("reset_status", {busy, done, ld_ready, st_valid, st_data}, '0);
    #9 rst = 1'b0;

    // All registers read zero on both ports after reset.
    for (int a = 0; a < NREGS; a++) begin
      rd_a_addr = AW'(a); rd_b_addr = AW'(NREGS - 1 - a);
      tick();
    end

    // Table of parallel write + same-cycle read vectors.
    tbl[0] = '{3'd3, ~(64'd1 << 5), 8'h00, 3'd3, 3'd3, '0, '0};
    tbl[1] = '{3'd3, 64'h0000_0000_0000_00F0, 8'h80, 3'd3, 3'd0, '0, '0};
    tbl[2] = '{3'd0, {64{1'b1}}, 8'hF0, 3'd0, 3'd3, '0, '0};
    tbl[3] = '{3'd7, 64'hAAAA_AAAA_AAAA_AAAA, 8'h10, 3'd7, 3'd0, '0, '0};
    tbl[4] = '{3'd7, 64'h0, 8'hFF, 3'd7, 3'd6, '0, '0};
    tbl[5] = '{3'd6, 64'h8000_0000_0000_0001, 8'h33, 3'd6, 3'd7, '0, '0};
    for (int r = 0; r < NREGS; r++)
      for (int i = 0; i < N; i++) tm[r][i] = '0;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < N; i++)
        if (tbl[k].mask[i]) tm[tbl[k].wa][i] = 8'(tbl[k].base + i);
      for (int i = 0; i < N; i++) begin
        tbl[k].exp_a[i*BITS +: BITS] = tm[tbl[k].ra][i];
        tbl[k].exp_b[i*BITS +: BITS] = tm[tbl[k].rb][i];
      end
    end
    for (int k = 0; k < 6; k++) begin
      wr_en = 1'b1; wr_addr = tbl[k].wa; wr_mask = tbl[k].mask;
      for (int i = 0; i < N; i++) wr_data[i] = 8'(tbl[k].base + i);
      rd_a_addr = tbl[k].ra; rd_b_addr = tbl[k].rb;
      tick();
      chk($sformatf("tbl%0d_a", k), rd_a_data, tbl[k].exp_a);
      chk($sformatf("tbl%0d_b", k), rd_b_data, tbl[k].exp_b);
    end
    idle_inputs();
    rd_a_addr = 3'd6; rd_b_addr = 3'd3;
    tick();

    // Asynchronous reset between edges clears outputs immediately.
    #3 rst = 1'b1;
    #1;
    chk("async_rst_rd", {rd_a_data, rd_b_data}, '0);
    chk("async_rst_status", {busy, done, ld_ready, st_valid, st_data}, '0);
    model_clear();
    #3 rst = 1'b0;
    tick();

    // Load reg 2 with ld_valid toggling every other cycle.
    ld_start = 1'b1; ld_addr = 3'd2; rd_a_addr = 3'd2;
    tick();
    ld_start = 1'b0;
    hs_cnt = 0; dones = 0; seen = 1'b0;
    for (int c = 0; c < 400 && !seen; c++) begin
      ld_valid = c[0];
      ld_data = 8'(8'hA0 + hs_cnt);
      if (ld_valid && ld_ready) hs_cnt++;
      tick();
      if (done) begin dones++; seen = 1'b1; end
    end
    ld_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin tick(); if (done) dones++; end
    chk("load_handshakes", 32'(hs_cnt), 32'(N));
    chk("load_done_pulses", 32'(dones), 32'd1);
    for (int i = 0; i < N; i++) expv[i*BITS +: BITS] = 8'(8'hA0 + i);
    chk("load_reg2", rd_a_data, expv);

    // Store reg 2 with random st_ready.
    st_start = 1'b1; st_addr = 3'd2;
    tick();
    st_start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 600 && !seen; c++) begin
      st_ready = 1'($urandom_range(0, 1));
      if (st_valid && st_ready) q.push_back(st_data);
      tick();
      if (done) seen = 1'b1;
    end
    st_ready = 1'b0;
    chk("store_done_seen", 32'(seen), 32'd1);
    chk("store_count", 32'(q.size()), 32'(N));
    bad = 0;
    for (int i = 0; i < q.size(); i++) if (q[i] !== 8'(8'hA0 + i)) bad++;
    chk("store_sequence", 32'(bad), 32'd0);
    tick();
    chk("store_valid_after", 32'(st_valid), 32'd0);

    // Both starts together: load wins; st_start ignored during load.
    ld_start = 1'b1; st_start = 1'b1; ld_addr = 3'd4; st_addr = 3'd5;
    tick();
    chk("both_start", {ld_ready, st_valid, busy}, 3'b101);
    ld_start = 1'b0; ld_valid = 1'b1;
    busy_gap = 0; seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      ld_data = 8'($urandom);
      tick();
      if (done) seen = 1'b1;
      else if (!busy || st_valid) busy_gap++;
    end
    ld_valid = 1'b0;
    chk("load_busy_until_done", {31'(busy_gap), seen}, {31'd0, 1'b1});
    // st_start still high in the done cycle: store begins at the next edge.
    tick();
    chk("start_in_done_cycle", {st_valid, busy}, 2'b11);
    st_start = 1'b0; st_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin tick(); if (done) seen = 1'b1; end
    st_ready = 1'b0;
    chk("store5_done", 32'(seen), 32'd1);

    // Collision on reg 1 lane 4, then reset mid-load at idx 10.
    ld_start = 1'b1; ld_addr = 3'd1; rd_a_addr = 3'd1;
    tick();
    ld_start = 1'b0; ld_valid = 1'b1;
    hs_cnt = 0;
    while (hs_cnt < 10) begin
      ld_data = 8'($urandom_range(0, 255));
      if (hs_cnt == 4) begin
        wr_en = 1'b1; wr_addr = 3'd1; wr_mask = 64'd1 << 4;
        wr_data = '0; wr_data[4] = 8'h55;
      end else begin
        wr_en = 1'b0;
      end
      tick();
      if (hs_cnt == 4) chk("collision_lane4", 32'(rd_a_data[4]), 32'h55);
      hs_cnt++;
    end
    idle_inputs();
    rd_a_addr = 3'd1;
    #3 rst = 1'b1;
    #1;
    chk("midload_rst", {busy, done, ld_ready, rd_a_data}, '0);
    model_clear();
    @(posedge clk); #1;
    chk("midload_no_done", 32'(done), 32'd0);
    #3 rst = 1'b0;
    tick();
    chk("reg1_cleared", rd_a_data, '0);

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      wr_en = 1'($urandom_range(0, 1));
      wr_addr = AW'($urandom_range(0, NREGS - 1));
      wr_mask = {$urandom, $urandom};
      for (int i = 0; i < N; i++) wr_data[i] = 8'($urandom);
      rd_a_addr = AW'($urandom_range(0, NREGS - 1));
      rd_b_addr = AW'($urandom_range(0, NREGS - 1));
      ld_start = ($urandom_range(0, 31) == 0);
      st_start = ($urandom_range(0, 15) == 0);
      ld_addr = AW'($urandom_range(0, NREGS - 1));
      st_addr = AW'($urandom_range(0, NREGS - 1));
      ld_data = 8'($urandom);
      ld_valid = 1'($urandom_range(0, 1));
      st_ready = 1'($urandom_range(0, 1));
      tick();
    end
    idle_inputs();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
